// File: rtl/booth_pair_divider_if.sv
// Start/done handshake and operand/result bus for the sequential divider.
interface booth_pair_divider_if #(parameter int WIDTH = 8);
  logic             go;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             over;
  logic             dz;
  logic [1:0]       state;

  // Controller side: issues operands and go, watches results.
  modport master (output go, dividend, divisor,
                  input  quotient, remainder, over, dz, state);
  // Divider side.
  modport slave  (input  go, dividend, divisor,
                  output quotient, remainder, over, dz, state);
endinterface

// File: rtl/booth_pair_divider.sv
// Unsigned restoring divider, one quotient bit per clock.
// Shares the go/over/state handshake with the Booth multiplier.
module booth_pair_divider #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  booth_pair_divider_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;       // dividend shifts out, quotient shifts in
  logic [WIDTH:0]   rem_q, rem_d;   // one guard bit so the trial can go negative
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dz_q, dz_d;

  logic [WIDTH:0]   t, trial;

  // Shift the next dividend bit into the partial remainder and try a subtract.
  assign t     = {rem_q[WIDTH-1:0], q_q[WIDTH-1]};
  assign trial = t - {1'b0, dvs_q};

  // State and datapath registers; rst wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      q_q     <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      dz_q    <= dz_d;
    end
  end

  // Next-state and datapath update; everything holds unless a state acts on it.
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    dz_d    = dz_q;
    case (state_q)
      IDLE: begin
        if (bus.go) begin
          cnt_d = '0;
          if (bus.divisor != '0) begin
            dvs_d   = bus.divisor;
            q_d     = bus.dividend;
            rem_d   = '0;
            dz_d    = 1'b0;
            state_d = RUN;
          end else begin
            // Divide-by-zero: publish the saturated result without iterating.
            q_d     = '1;
            rem_d   = {1'b0, bus.dividend};
            dz_d    = 1'b1;
            state_d = DONE;
          end
        end
      end
      RUN: begin
        cnt_d = cnt_q + CW'(1);
        if (!trial[WIDTH]) begin
          rem_d = trial;
          q_d   = {q_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = t;
          q_d   = {q_q[WIDTH-2:0], 1'b0};
        end
        if (cnt_q == LAST) state_d = DONE;
      end
      DONE: begin
        // Hold until go drops so a held go cannot retrigger.
        if (!bus.go) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.quotient  = q_q;
  assign bus.remainder = rem_q[WIDTH-1:0];
  assign bus.dz        = dz_q;
  assign bus.over      = (state_q == DONE);
  assign bus.state     = state_q;

endmodule
